// File: rtl/irq_sched.sv
// Sequential interrupt scheduler: edge capture into per-bus pending registers, fixed bus priority
// A > B > C, grant held until ack or timeout. Optional macro IRQ_RR_EN enables per-bus round-robin.
module irq_sched #(
   parameter int NCH     = 9,
   parameter int TIMEOUT = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [NCH-1:0] req_a,
   input  logic [NCH-1:0] req_b,
   input  logic [NCH-1:0] req_c,
   input  logic [NCH-1:0] mask_en,
   input  logic           irq_ack,
   output logic           irq_valid,
   output logic [1:0]     irq_bus,
   output logic [3:0]     irq_chan,
   output logic           busy_a,
   output logic           busy_b,
   output logic           busy_c,
   output logic           irq_timeout
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ARB, GRANT} state_t;

   state_t                  state_reg, state_next;
   logic [2:0][NCH-1:0]     req_v, prev_reg, pend_reg, pend_next, elig, clr_mask;
   logic [1:0]              bus_reg, bus_next;
   logic [3:0]              chan_reg, chan_next;
   logic [CW-1:0]           cnt_reg, cnt_next;
   logic                    timeout_reg, timeout_next;
   logic                    ack_clr;
   logic [NCH-1:0]          chan_onehot;
   logic                    win_found;
   logic [1:0]              win_bus;
   logic [3:0]              win_chan;
   logic [2:0][3:0]         start_ptr;

   assign req_v       = {req_c, req_b, req_a};
   assign ack_clr     = (state_reg == GRANT) && irq_ack;
   assign chan_onehot = {{(NCH-1){1'b0}}, 1'b1} << chan_reg;

   // Per-bus edge capture; a set edge on the same cycle as the ack clear wins.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : gen_bus
         assign clr_mask[gi]  = (ack_clr && (bus_reg == 2'(gi))) ? chan_onehot : '0;
         assign pend_next[gi] = (pend_reg[gi] & ~clr_mask[gi]) |
                                (req_v[gi] & ~prev_reg[gi] & mask_en);
         assign elig[gi]      = pend_reg[gi] & mask_en;
      end
   endgenerate

`ifdef IRQ_RR_EN
   logic [2:0][3:0] ptr_reg;

   assign start_ptr = ptr_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_reg <= '0;
      end else if (ack_clr) begin
         ptr_reg[bus_reg] <= (int'(chan_reg) == NCH - 1) ? 4'd0 : chan_reg + 4'd1;
      end
   end
`else
   assign start_ptr = '0;
`endif

   // Reverse scan so the last hit is the highest priority: lowest bus, then first channel from the pointer.
   always_comb begin
      win_found = 1'b0;
      win_bus   = 2'd0;
      win_chan  = 4'd0;
      for (int b = 2; b >= 0; b--) begin
         for (int i = NCH - 1; i >= 0; i--) begin
            int idx;
            idx = int'(start_ptr[b]) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (elig[b][idx]) begin
               win_found = 1'b1;
               win_bus   = 2'(b);
               win_chan  = 4'(idx);
            end
         end
      end
   end

   always_comb begin
      state_next   = state_reg;
      bus_next     = bus_reg;
      chan_next    = chan_reg;
      cnt_next     = cnt_reg;
      timeout_next = timeout_reg;
      case (state_reg)
         IDLE: begin
            if (|elig) state_next = ARB;
         end
         ARB: begin
            if (win_found) begin
               bus_next   = win_bus;
               chan_next  = win_chan;
               cnt_next   = '0;
               state_next = GRANT;
            end else begin
               state_next = IDLE;
            end
         end
         GRANT: begin
            if (irq_ack) begin
               state_next = IDLE;
            end else if ((TIMEOUT != 0) && (int'(cnt_reg) + 1 == TIMEOUT)) begin
               // Abandon the grant but keep the pend bit so it is arbitrated again.
               timeout_next = 1'b1;
               state_next   = IDLE;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         prev_reg    <= '0;
         pend_reg    <= '0;
         bus_reg     <= 2'd0;
         chan_reg    <= 4'd0;
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         prev_reg    <= req_v;
         pend_reg    <= pend_next;
         bus_reg     <= bus_next;
         chan_reg    <= chan_next;
         cnt_reg     <= cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign irq_valid   = (state_reg == GRANT);
   assign irq_bus     = bus_reg;
   assign irq_chan    = chan_reg;
   assign busy_a      = |elig[0];
   assign busy_b      = |elig[1];
   assign busy_c      = |elig[2];
   assign irq_timeout = timeout_reg;

endmodule

// File: tb/tb_irq_sched.sv
// Directed testbench for irq_sched: latency, priority order, masking, timeout, reset and channel order.
module tb_irq_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [8:0] req_a, req_b, req_c, mask_en;
   logic       irq_ack;
   logic       irq_valid;
   logic [1:0] irq_bus;
   logic [3:0] irq_chan;
   logic       busy_a, busy_b, busy_c, irq_timeout;

   int n_checks = 0;
   int n_errors = 0;

   irq_sched #(.NCH(9), .TIMEOUT(15)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_c       (req_c),
      .mask_en     (mask_en),
      .irq_ack     (irq_ack),
      .irq_valid   (irq_valid),
      .irq_bus     (irq_bus),
      .irq_chan    (irq_chan),
      .busy_a      (busy_a),
      .busy_b      (busy_b),
      .busy_c      (busy_c),
      .irq_timeout (irq_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_grant(input string tag, input int b, input int c);
      int n;
      n = 0;
      while (!irq_valid && n < 20) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(irq_valid), 32'd1);
      chk({tag, "_bus"}, 32'(irq_bus), 32'(b));
      chk({tag, "_chan"}, 32'(irq_chan), 32'(c));
      $display("grant %s: bus=%0d chan=%0d (expected %0d/%0d) waited=%0d", tag, irq_bus, irq_chan, b, c, n);
   endtask

   task automatic do_ack(input string tag);
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
      chk({tag, "_ackdrop"}, 32'(irq_valid), 32'd0);
   endtask

   initial begin
      int n;
      int exp2, exp3;
      rst = 1'b1; req_a = '0; req_b = '0; req_c = '0; mask_en = 9'h1FF; irq_ack = 1'b0;
      tick();
      tick();
      chk("rst_out", {irq_valid, irq_bus, irq_chan, busy_a, busy_b, busy_c, irq_timeout}, 0);
      rst = 1'b0;

      // single request: grant visible after the third edge
      req_a[3] = 1'b1;
      tick();
      chk("t1_e1_valid", 32'(irq_valid), 0);
      chk("t1_e1_busy", 32'(busy_a), 1);
      tick();
      chk("t1_e2_valid", 32'(irq_valid), 0);
      tick();
      chk("t1_e3_valid", 32'(irq_valid), 1);
      expect_grant("a3", 0, 3);
      req_a[3] = 1'b0;
      do_ack("a3");
      chk("t1_busy_clr", 32'(busy_a), 0);

      // simultaneous requests on three buses, exactly two idle cycles between grants
      req_a[8] = 1'b1; req_b[5] = 1'b1; req_c[0] = 1'b1;
      tick(); tick(); tick();
      expect_grant("a8", 0, 8);
      do_ack("a8");
      tick();
      chk("gap1_arb", 32'(irq_valid), 0);
      tick();
      chk("gap1_grant", 32'(irq_valid), 1);
      expect_grant("b5", 1, 5);
      do_ack("b5");
      tick();
      chk("gap2_arb", 32'(irq_valid), 0);
      tick();
      chk("gap2_grant", 32'(irq_valid), 1);
      expect_grant("c0", 2, 0);
      do_ack("c0");
      req_a[8] = 1'b0; req_b[5] = 1'b0; req_c[0] = 1'b0;
      chk("t2_busy", {busy_a, busy_b, busy_c}, 0);

      // ack during IDLE/ARB is ignored
      req_a[5] = 1'b1;
      irq_ack = 1'b1;
      tick(); tick(); tick();
      irq_ack = 1'b0;
      chk("ackign_valid", 32'(irq_valid), 1);
      chk("ackign_chan", 32'(irq_chan), 5);
      req_a[5] = 1'b0;
      do_ack("a5");

      // edge while masked produces no pending request
      mask_en[2] = 1'b0;
      req_b[2] = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (irq_valid) n++;
      end
      chk("mask_edge_busy", 32'(busy_b), 0);
      chk("mask_edge_nogrant", n, 0);
      req_b[2] = 1'b0;
      tick();
      mask_en = 9'h1FF;

      // pending bit kept while masked; grant not revoked by mask drop
      req_a[1] = 1'b1;
      expect_grant("a1m", 0, 1);
      req_a[1] = 1'b0;
      req_b[2] = 1'b1;
      tick();
      chk("b2_busy", 32'(busy_b), 1);
      mask_en = 9'h1F9;
      tick();
      chk("norevoke_valid", 32'(irq_valid), 1);
      chk("norevoke_chan", 32'(irq_chan), 1);
      chk("b2_masked_busy", 32'(busy_b), 0);
      do_ack("a1m");
      n = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (irq_valid) n++;
      end
      chk("masked_nogrant", n, 0);
      mask_en = 9'h1FF;
      #1;
      chk("unmask_busy", 32'(busy_b), 1);
      expect_grant("b2", 1, 2);
      req_b[2] = 1'b0;
      do_ack("b2");

      // timeout after 15 GRANT cycles, pend retained
      req_a[1] = 1'b1;
      tick();
      req_a[1] = 1'b0;
      expect_grant("a1t", 0, 1);
      chk("pre_timeout", 32'(irq_timeout), 0);
      n = 1;
      tick();
      while (irq_valid && n < 40) begin
         n++;
         tick();
      end
      chk("grant_cycles", n, 15);
      chk("timeout_flag", 32'(irq_timeout), 1);
      expect_grant("a1re", 0, 1);
      do_ack("a1re");
      chk("timeout_sticky", 32'(irq_timeout), 1);

      // reset during GRANT with request held high
      req_a[0] = 1'b1;
      expect_grant("a0pre", 0, 0);
      rst = 1'b1;
      tick();
      chk("rst_grant_out", {irq_valid, irq_bus, irq_chan, busy_a, busy_b, busy_c, irq_timeout}, 0);
      rst = 1'b0;
      tick();
      chk("post_rst_e1", 32'(irq_valid), 0);
      chk("post_rst_busy", 32'(busy_a), 1);
      tick();
      chk("post_rst_e2", 32'(irq_valid), 0);
      tick();
      chk("post_rst_e3", 32'(irq_valid), 1);
      expect_grant("a0post", 0, 0);
      req_a[0] = 1'b0;
      do_ack("a0post");

      // channel order within a bus with re-pulsed requests
`ifdef IRQ_RR_EN
      exp2 = 4; exp3 = 0;
`else
      exp2 = 0; exp3 = 4;
`endif
      req_a[0] = 1'b1; req_a[4] = 1'b1;
      tick();
      req_a[0] = 1'b0; req_a[4] = 1'b0;
      expect_grant("ord1", 0, 0);
      do_ack("ord1");
      req_a[0] = 1'b1;
      tick();
      req_a[0] = 1'b0;
      expect_grant("ord2", 0, exp2);
      do_ack("ord2");
      req_a[4] = 1'b1;
      tick();
      req_a[4] = 1'b0;
      expect_grant("ord3", 0, exp3);
      do_ack("ord3");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
